// File: rtl/cache_mem_bridge_pkg.sv
// cache_mem_bridge_pkg: shared widths, FSM encodings and address helper for the cache/memory bridge
package cache_mem_bridge_pkg;
   localparam int PA_WIDTH  = 32;
   localparam int WRD_WIDTH = 32;
   localparam int MEM_WIDTH = 512;
   localparam int WPB       = MEM_WIDTH / WRD_WIDTH;
   localparam int BO_WIDTH  = 6;
   localparam int CW        = $clog2(WPB);
   localparam logic [2:0] MB_IDLE    = 3'd0;
   localparam logic [2:0] MB_WB      = 3'd1;
   localparam logic [2:0] MB_RF_ISS  = 3'd2;
   localparam logic [2:0] MB_RF_WAIT = 3'd3;
   localparam logic [2:0] MB_DONE    = 3'd4;
   function automatic logic [PA_WIDTH-1:0] block_base(input logic [PA_WIDTH-1:0] a);
      return {a[PA_WIDTH-1:BO_WIDTH], {BO_WIDTH{1'b0}}};
   endfunction
endpackage

// File: rtl/mem_beat_ctr.sv
// mem_beat_ctr: per-block beat counter, wraps after the last word of a block
module mem_beat_ctr
   import cache_mem_bridge_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          last
);
   always_ff @(posedge clk)
      if (!rst_n || clr) cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
   assign last = cnt == CW'(WPB - 1);
endmodule

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: serialises victim blocks to word writes and assembles refill blocks from word reads
module cache_mem_bridge
   import cache_mem_bridge_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wb_req,
   input  logic [PA_WIDTH-1:0]  wb_addr,
   input  logic [MEM_WIDTH-1:0] wb_data,
   output logic                 wb_done,
   input  logic                 rf_req,
   input  logic [PA_WIDTH-1:0]  rf_addr,
   output logic [MEM_WIDTH-1:0] rf_data,
   output logic                 rf_done,
   output logic                 busy,
   output logic                 m_req,
   output logic                 m_we,
   output logic [PA_WIDTH-1:0]  m_addr,
   output logic [WRD_WIDTH-1:0] m_wdata,
   input  logic                 m_gnt,
   input  logic                 m_rvalid,
   input  logic [WRD_WIDTH-1:0] m_rdata
);
   logic [2:0]           state;
   logic                 is_wb;
   logic [PA_WIDTH-1:0]  base;
   logic [MEM_WIDTH-1:0] blk;
   logic [CW-1:0]        iss, rsp;
   logic                 iss_last, rsp_last, iss_inc, rsp_inc, clr_ctrs;
   assign m_req    = state == MB_WB || state == MB_RF_ISS;
   assign m_we     = state == MB_WB;
   assign busy     = state != MB_IDLE;
   assign wb_done  = state == MB_DONE && is_wb;
   assign rf_done  = state == MB_DONE && !is_wb;
   assign m_addr   = m_req ? base + PA_WIDTH'({iss, 2'b00}) : '0;
   assign m_wdata  = m_we ? blk[iss*WRD_WIDTH +: WRD_WIDTH] : '0;
   assign iss_inc  = m_req && m_gnt;
   // responses only count while a refill is in flight; anything else is stray
   assign rsp_inc  = m_rvalid && (state == MB_RF_ISS || state == MB_RF_WAIT);
   assign clr_ctrs = state == MB_DONE;
   mem_beat_ctr u_iss (.clk(clk), .rst_n(rst_n), .inc(iss_inc), .clr(clr_ctrs), .cnt(iss), .last(iss_last));
   mem_beat_ctr u_rsp (.clk(clk), .rst_n(rst_n), .inc(rsp_inc), .clr(clr_ctrs), .cnt(rsp), .last(rsp_last));
   always_ff @(posedge clk)
      if (!rst_n) begin
         state   <= MB_IDLE;
         is_wb   <= 1'b0;
         base    <= '0;
         blk     <= '0;
         rf_data <= '0;
      end else begin
         if (rsp_inc) rf_data[rsp*WRD_WIDTH +: WRD_WIDTH] <= m_rdata;
         case (state)
            MB_IDLE:
               if (wb_req) begin
                  state <= MB_WB;
                  is_wb <= 1'b1;
                  base  <= block_base(wb_addr);
                  blk   <= wb_data;
               end else if (rf_req) begin
                  state <= MB_RF_ISS;
                  is_wb <= 1'b0;
                  base  <= block_base(rf_addr);
               end
            MB_WB:      if (iss_inc && iss_last) state <= MB_DONE;
            MB_RF_ISS:  if (iss_inc && iss_last) state <= rsp_inc && rsp_last ? MB_DONE : MB_RF_WAIT;
            MB_RF_WAIT: if (rsp_inc && rsp_last) state <= MB_DONE;
            default:    state <= MB_IDLE;
         endcase
      end
endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge: directed scenarios for cache_mem_bridge with a small memory responder
module tb_cache_mem_bridge;
   logic         clk = 0, rst_n = 0;
   logic         wb_req = 0, rf_req = 0, m_gnt = 0, m_rvalid = 0;
   logic [31:0]  wb_addr = 0, rf_addr = 0, m_rdata = 0;
   logic [511:0] wb_data = 0;
   logic         wb_done, rf_done, busy, m_req, m_we;
   logic [511:0] rf_data;
   logic [31:0]  m_addr, m_wdata;
   int checks = 0, passed = 0;
   int cyc, wb_beats, rf_beats, rvs, wb_dones, rf_dones, wb_done_cyc, rf_done_cyc;
   int last_rv_cyc, rf_start_cyc, bad_beats, lat;
   int due_q[$];
   logic [31:0]  wb_base, rf_base, rd_base, bad_addr;
   logic [511:0] exp_blk;

   cache_mem_bridge dut (
      .clk(clk), .rst_n(rst_n), .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_done(wb_done), .rf_req(rf_req), .rf_addr(rf_addr), .rf_data(rf_data),
      .rf_done(rf_done), .busy(busy), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   task automatic clr_stats();
      cyc = 0; wb_beats = 0; rf_beats = 0; rvs = 0; wb_dones = 0; rf_dones = 0;
      wb_done_cyc = -1; rf_done_cyc = -1; last_rv_cyc = -1; rf_start_cyc = -1;
      bad_beats = 0; bad_addr = 0;
      due_q.delete();
   endtask

   // one cycle: drive memory inputs, record what the bridge shows, then advance past the edge
   task automatic step(input bit gnt);
      logic [31:0] ea, ed;
      m_gnt    = gnt;
      m_rvalid = due_q.size() > 0 && due_q[0] == cyc;
      m_rdata  = m_rvalid ? rd_base + 32'(rvs) : 32'h5A5A_5A5A;
      if (m_rvalid) begin
         void'(due_q.pop_front());
         rvs++;
         last_rv_cyc = cyc;
      end
      if (m_req) begin
         ea = m_we ? wb_base + 32'(4 * (wb_beats % 16)) : rf_base + 32'(4 * rf_beats);
         ed = 32'hA000_0000 + 32'(wb_beats % 16);
         if (m_addr !== ea || (m_we && m_wdata !== ed)) begin
            bad_beats++;
            bad_addr = m_addr;
         end
         if (!m_we && rf_start_cyc < 0) rf_start_cyc = cyc;
         if (gnt) begin
            if (m_we) wb_beats++;
            else begin
               rf_beats++;
               due_q.push_back(cyc + lat);
            end
         end
      end
      if (wb_done) begin wb_dones++; wb_done_cyc = cyc; end
      if (rf_done) begin rf_dones++; rf_done_cyc = cyc; end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic test_reset();
      clr_stats();
      rst_n = 0;
      step(0);
      step(0);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      checks++; if (m_req !== 1'b0 || m_we !== 1'b0) $display("FAIL reset_mreq got %b%b want 00", m_req, m_we); else passed++;
      checks++; if (m_addr !== 32'h0) $display("FAIL reset_maddr got %h want 0", m_addr); else passed++;
      checks++; if (m_wdata !== 32'h0) $display("FAIL reset_mwdata got %h want 0", m_wdata); else passed++;
      checks++; if (wb_done !== 1'b0 || rf_done !== 1'b0) $display("FAIL reset_done got %b%b want 00", wb_done, rf_done); else passed++;
      checks++; if (rf_data !== 512'h0) $display("FAIL reset_rfdata got %h want 0", rf_data); else passed++;
      rst_n = 1;
      step(0);
   endtask

   task automatic test_wb_basic();
      clr_stats();
      wb_base = 32'h0000_1200; wb_addr = 32'h0000_1234; wb_req = 1;
      step(1);
      wb_req = 0;
      for (int i = 0; i < 40 && wb_dones == 0; i++) step(1);
      step(1); step(1);
      checks++; if (bad_beats !== 0) $display("FAIL wb_beat_content got %0d bad (last addr %h) want 0", bad_beats, bad_addr); else passed++;
      checks++; if (wb_beats !== 16) $display("FAIL wb_beat_count got %0d want 16", wb_beats); else passed++;
      checks++; if (wb_done_cyc !== 17) $display("FAIL wb_done_cycle got %0d want 17", wb_done_cyc); else passed++;
      checks++; if (wb_dones !== 1) $display("FAIL wb_done_pulses got %0d want 1", wb_dones); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL wb_idle_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_wb_stall();
      clr_stats();
      wb_base = 32'hFFFF_FFC0; wb_addr = 32'hFFFF_FFC8; wb_req = 1;
      step(1);
      wb_req = 0;
      for (int i = 0; i < 80 && wb_dones == 0; i++) step(cyc % 2 == 1);
      step(1); step(1);
      checks++; if (bad_beats !== 0) $display("FAIL stall_hold got %0d bad (last addr %h) want 0", bad_beats, bad_addr); else passed++;
      checks++; if (wb_beats !== 16) $display("FAIL stall_beat_count got %0d want 16", wb_beats); else passed++;
      checks++; if (wb_dones !== 1) $display("FAIL stall_done_pulses got %0d want 1", wb_dones); else passed++;
      checks++; if (wb_done_cyc !== 32) $display("FAIL stall_done_cycle got %0d want 32", wb_done_cyc); else passed++;
   endtask

   task automatic test_refill();
      clr_stats();
      lat = 3; rd_base = 32'hB000_0000;
      rf_base = 32'h0000_8040; rf_addr = 32'h0000_8040; rf_req = 1;
      step(1);
      rf_req = 0;
      for (int i = 0; i < 60 && rf_dones == 0; i++) step(1);
      checks++; if (bad_beats !== 0) $display("FAIL rf_addr_seq got %0d bad (last addr %h) want 0", bad_beats, bad_addr); else passed++;
      checks++; if (rf_beats !== 16) $display("FAIL rf_beat_count got %0d want 16", rf_beats); else passed++;
      checks++; if (rvs !== 16) $display("FAIL rf_resp_count got %0d want 16", rvs); else passed++;
      checks++; if (rf_done_cyc !== 20) $display("FAIL rf_done_cycle got %0d want 20", rf_done_cyc); else passed++;
      checks++; if (rf_done_cyc !== last_rv_cyc + 1) $display("FAIL rf_done_after_resp got %0d want %0d", rf_done_cyc, last_rv_cyc + 1); else passed++;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (rf_data[32*k +: 32] !== 32'hB000_0000 + 32'(k))
            $display("FAIL rf_word%0d got %h want %h", k, rf_data[32*k +: 32], 32'hB000_0000 + 32'(k));
         else passed++;
      end
   endtask

   task automatic test_both();
      clr_stats();
      lat = 1; rd_base = 32'hD000_0000;
      wb_base = 32'h0000_2000; wb_addr = 32'h0000_2000;
      rf_base = 32'h0000_3000; rf_addr = 32'h0000_3010;
      wb_req = 1; rf_req = 1;
      step(1);
      wb_req = 0;
      for (int i = 0; i < 40 && wb_dones == 0; i++) step(1);
      step(1);
      rf_req = 0;
      for (int i = 0; i < 60 && rf_dones == 0; i++) step(1);
      checks++; if (wb_done_cyc !== 17) $display("FAIL both_wb_done got %0d want 17", wb_done_cyc); else passed++;
      checks++; if (rf_start_cyc !== 19) $display("FAIL both_rf_start got %0d want 19", rf_start_cyc); else passed++;
      checks++; if (wb_beats !== 16 || rf_beats !== 16) $display("FAIL both_beats got %0d/%0d want 16/16", wb_beats, rf_beats); else passed++;
      checks++; if (bad_beats !== 0) $display("FAIL both_beat_content got %0d bad (last addr %h) want 0", bad_beats, bad_addr); else passed++;
      checks++; if (rf_done_cyc !== 36) $display("FAIL both_rf_done got %0d want 36", rf_done_cyc); else passed++;
      checks++; if (rf_data[511:480] !== 32'hD000_000F) $display("FAIL both_rf_word15 got %h want d000000f", rf_data[511:480]); else passed++;
   endtask

   task automatic test_reset_mid();
      clr_stats();
      lat = 3; rd_base = 32'hE000_0000;
      rf_base = 32'h0000_4440; rf_addr = 32'h0000_4444; rf_req = 1;
      step(1);
      rf_req = 0;
      for (int i = 0; i < 20 && rf_beats < 5; i++) step(1);
      rst_n = 0;
      step(0);
      checks++; if (m_req !== 1'b0) $display("FAIL midrst_mreq got %b want 0", m_req); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
      checks++; if (rf_data !== 512'h0) $display("FAIL midrst_rfdata got %h want 0", rf_data); else passed++;
      rst_n = 1;
      for (int i = 0; i < 6; i++) step(1);
      checks++; if (rf_data !== 512'h0 || busy !== 1'b0) $display("FAIL midrst_stray got busy %b data %h want 0/0", busy, rf_data); else passed++;
      clr_stats();
      rd_base = 32'hC000_0000;
      rf_req = 1;
      step(1);
      rf_req = 0;
      for (int i = 0; i < 60 && rf_dones == 0; i++) step(1);
      for (int k = 0; k < 16; k++) exp_blk[32*k +: 32] = 32'hC000_0000 + 32'(k);
      checks++; if (rf_beats !== 16 || bad_beats !== 0) $display("FAIL midrst_refill_beats got %0d beats %0d bad want 16/0", rf_beats, bad_beats); else passed++;
      checks++; if (rf_data !== exp_blk) $display("FAIL midrst_refill_data got %h want %h", rf_data, exp_blk); else passed++;
   endtask

   task automatic test_spurious();
      clr_stats();
      lat = 3; rd_base = 32'h1111_0000;
      due_q = '{0, 1, 2, 3, 17, 18};
      wb_base = 32'h0000_0100; wb_addr = 32'h0000_0100; wb_req = 1;
      for (int i = 0; i < 80 && wb_dones < 2; i++) step(1);
      wb_req = 0;
      step(1);
      checks++; if (rf_data !== exp_blk) $display("FAIL spur_rfdata got %h want %h", rf_data, exp_blk); else passed++;
      checks++; if (wb_dones !== 2) $display("FAIL spur_held_req got %0d done pulses want 2", wb_dones); else passed++;
      checks++; if (wb_done_cyc !== 35) $display("FAIL spur_second_done got %0d want 35", wb_done_cyc); else passed++;
      checks++; if (wb_beats !== 32 || bad_beats !== 0) $display("FAIL spur_beats got %0d beats %0d bad want 32/0", wb_beats, bad_beats); else passed++;
      checks++; if (rf_dones !== 0) $display("FAIL spur_rf_done got %0d want 0", rf_dones); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL spur_idle_busy got %b want 0", busy); else passed++;
   endtask

   initial begin
      for (int k = 0; k < 16; k++) wb_data[32*k +: 32] = 32'hA000_0000 + 32'(k);
      lat = 3; rd_base = 0; wb_base = 0; rf_base = 0; exp_blk = 0;
      #1;
      test_reset();
      test_wb_basic();
      test_wb_stall();
      test_refill();
      test_both();
      test_reset_mid();
      test_spurious();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
